// File: rtl/axi_lite_master_engine_if.sv
// AXI4-Lite bus bundle between the master engine and a register slave.
interface axi_lite_master_engine_if #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 16
) ();
  logic [C_AXI_ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]                    awprot;
  logic                          awvalid;
  logic                          awready;
  logic [C_AXI_DATA_WIDTH-1:0]   wdata;
  logic [C_AXI_DATA_WIDTH/8-1:0] wstrb;
  logic                          wvalid;
  logic                          wready;
  logic [1:0]                    bresp;
  logic                          bvalid;
  logic                          bready;
  logic [C_AXI_ADDR_WIDTH-1:0]   araddr;
  logic [2:0]                    arprot;
  logic                          arvalid;
  logic                          arready;
  logic [C_AXI_DATA_WIDTH-1:0]   rdata;
  logic [1:0]                    rresp;
  logic                          rvalid;
  logic                          rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_master_engine.sv
// Single-outstanding AXI4-Lite master: one command in, one AXI transaction out,
// one response back, with a B/R timeout that locks the engine until reset.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for a command (cmd_ready unless hung)
// S_WR_AW_W | awvalid/wvalid pending, each cleared by its own handshake
// S_WR_B    | bready high, timer running
// S_RD_AR   | arvalid pending
// S_RD_R    | rready high, timer running
// S_RESP    | rsp_valid held until rsp_ready
module axi_lite_master_engine #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 16,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic                          axi_aclk,
  input  logic                          axi_areset,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [C_AXI_DATA_WIDTH-1:0]   rsp_data,
  output logic [1:0]                    rsp_resp,
  output logic                          rsp_timeout,
  output logic                          err_hung,
  axi_lite_master_engine_if.master      axi
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_AW_W = 3'd1;
  localparam logic [2:0] S_WR_B    = 3'd2;
  localparam logic [2:0] S_RD_AR   = 3'd3;
  localparam logic [2:0] S_RD_R    = 3'd4;
  localparam logic [2:0] S_RESP    = 3'd5;

  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Down-counter loaded with TIMEOUT_CYCLES-1; reaching zero without a handshake expires.
  localparam bit                TMR_EN   = (TIMEOUT_CYCLES > 0);
  localparam int                TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]     TMR_LOAD = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [2:0]    state;
  logic [TW-1:0] tmr;
  logic          aw_hs;
  logic          w_hs;
  logic          tmr_expired;

  assign axi.awprot  = 3'b000;
  assign axi.arprot  = 3'b000;
  assign aw_hs       = axi.awvalid && axi.awready;
  assign w_hs        = axi.wvalid && axi.wready;
  assign tmr_expired = TMR_EN && (tmr == '0);

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      state       <= S_IDLE;
      tmr         <= '0;
      cmd_ready   <= 1'b1;
      err_hung    <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_resp    <= 2'b00;
      rsp_timeout <= 1'b0;
      axi.awaddr  <= '0;
      axi.awvalid <= 1'b0;
      axi.wdata   <= '0;
      axi.wstrb   <= '0;
      axi.wvalid  <= 1'b0;
      axi.bready  <= 1'b0;
      axi.araddr  <= '0;
      axi.arvalid <= 1'b0;
      axi.rready  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            if (cmd_write) begin
              axi.awaddr  <= cmd_addr;
              axi.wdata   <= cmd_wdata;
              axi.wstrb   <= cmd_wstrb;
              axi.awvalid <= 1'b1;
              axi.wvalid  <= 1'b1;
              state       <= S_WR_AW_W;
            end else begin
              axi.araddr  <= cmd_addr;
              axi.arvalid <= 1'b1;
              state       <= S_RD_AR;
            end
          end
        end

        S_WR_AW_W: begin
          if (aw_hs) axi.awvalid <= 1'b0;
          if (w_hs)  axi.wvalid  <= 1'b0;
          if ((aw_hs || !axi.awvalid) && (w_hs || !axi.wvalid)) begin
            axi.bready <= 1'b1;
            tmr        <= TMR_LOAD;
            state      <= S_WR_B;
          end
        end

        S_WR_B: begin
          // A handshake on the expiry edge still counts as a normal response.
          if (axi.bvalid && axi.bready) begin
            axi.bready  <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_data    <= '0;
            rsp_resp    <= axi.bresp;
            rsp_timeout <= 1'b0;
            state       <= S_RESP;
          end else if (tmr_expired) begin
            axi.bready  <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_data    <= '0;
            rsp_resp    <= RESP_SLVERR;
            rsp_timeout <= 1'b1;
            err_hung    <= 1'b1;
            state       <= S_RESP;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end

        S_RD_AR: begin
          if (axi.arvalid && axi.arready) begin
            axi.arvalid <= 1'b0;
            axi.rready  <= 1'b1;
            tmr         <= TMR_LOAD;
            state       <= S_RD_R;
          end
        end

        S_RD_R: begin
          if (axi.rvalid && axi.rready) begin
            axi.rready  <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_data    <= axi.rdata;
            rsp_resp    <= axi.rresp;
            rsp_timeout <= 1'b0;
            state       <= S_RESP;
          end else if (tmr_expired) begin
            axi.rready  <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_data    <= '0;
            rsp_resp    <= RESP_SLVERR;
            rsp_timeout <= 1'b1;
            err_hung    <= 1'b1;
            state       <= S_RESP;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end

        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= !err_hung;
            state     <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_master_engine.sv
// Scoreboard bench: randomized AXI4-Lite slave, reference memory model and
// a response monitor decoupled from the command driver.
module tb_axi_lite_master_engine;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int TO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          areset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [3:0]    cmd_wstrb;
  logic          rsp_valid, rsp_ready, rsp_timeout, err_hung;
  logic [DW-1:0] rsp_data;
  logic [1:0]    rsp_resp;

  axi_lite_master_engine_if #(.C_AXI_DATA_WIDTH(DW), .C_AXI_ADDR_WIDTH(AW)) axi ();

  axi_lite_master_engine #(
    .C_AXI_DATA_WIDTH(DW), .C_AXI_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .axi_aclk(clk), .axi_areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .err_hung(err_hung),
    .axi(axi)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        to;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [int];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave model: random registered readies, configurable response delay.
  int          rdy_pct = 100;
  int          max_dly = 0;
  int          rsp_pct = 100;
  bit          aw_block = 1'b0;
  bit          no_b = 1'b0;
  bit          rd_err = 1'b0;
  logic [31:0] smem [0:16383];
  bit          aw_got, w_got, b_pend, r_pend;
  int          b_wait, r_wait;
  logic [15:0] aw_a, r_a;
  logic [31:0] w_d;
  logic [3:0]  w_s;
  int          b_hs = 0;
  int          rsp_cnt = 0;
  int          bready_cnt = 0;

  always @(posedge clk) begin
    if (areset) begin
      axi.awready <= 1'b0; axi.wready <= 1'b0; axi.arready <= 1'b0;
      axi.bvalid  <= 1'b0; axi.bresp  <= 2'b00;
      axi.rvalid  <= 1'b0; axi.rresp  <= 2'b00; axi.rdata <= '0;
      aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
    end else begin
      axi.awready <= !aw_block && ($urandom_range(99) < rdy_pct);
      axi.wready  <= ($urandom_range(99) < rdy_pct);
      axi.arready <= ($urandom_range(99) < rdy_pct);
      if (axi.awvalid && axi.awready) begin aw_got = 1; aw_a = axi.awaddr; end
      if (axi.wvalid && axi.wready) begin w_got = 1; w_d = axi.wdata; w_s = axi.wstrb; end
      if (axi.bvalid && axi.bready) begin axi.bvalid <= 1'b0; b_hs++; end
      if (aw_got && w_got) begin
        for (int b = 0; b < 4; b++)
          if (w_s[b]) smem[aw_a[15:2]][8*b +: 8] = w_d[8*b +: 8];
        aw_got = 0; w_got = 0; b_pend = 1;
        b_wait = $urandom_range(max_dly, 0);
      end
      if (b_pend && !no_b) begin
        if (b_wait == 0) begin axi.bvalid <= 1'b1; axi.bresp <= 2'b00; b_pend = 0; end
        else b_wait--;
      end
      if (axi.rvalid && axi.rready) axi.rvalid <= 1'b0;
      if (axi.arvalid && axi.arready) begin
        r_pend = 1; r_a = axi.araddr; r_wait = $urandom_range(max_dly, 0);
      end
      if (r_pend) begin
        if (r_wait == 0) begin
          axi.rvalid <= 1'b1;
          axi.rdata  <= rd_err ? 32'hDEADBEEF : smem[r_a[15:2]];
          axi.rresp  <= rd_err ? 2'b10 : 2'b00;
          r_pend = 0;
        end else r_wait--;
      end
    end
  end

  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 rsp_ready = ($urandom_range(99) < rsp_pct);
    end
  end

  exp_t mon_e;
  always @(negedge clk) begin
    if (!areset) begin
      if (axi.bready) bready_cnt++;
      if (rsp_valid && rsp_ready) begin
        rsp_cnt++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp: got data 0x%08h resp %0d with no expectation", rsp_data, rsp_resp);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rsp_data", rsp_data, mon_e.data);
          chk("rsp_resp", 32'(rsp_resp), 32'(mon_e.resp));
          chk("rsp_timeout", 32'(rsp_timeout), 32'(mon_e.to));
        end
      end
    end
  end

  function automatic void ref_wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] mask;
    logic [31:0] old;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    old  = ref_mem.exists(int'(a[15:2])) ? ref_mem[int'(a[15:2])] : 32'h0;
    ref_mem[int'(a[15:2])] = (old & ~mask) | (d & mask);
  endfunction

  task automatic do_cmd(input bit wr_n, input logic [15:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [31:0] ed, input logic [1:0] er,
                        input bit et);
    exp_t e;
    int   n;
    e.data = ed; e.resp = er; e.to = et;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cmd_valid = 1'b1; cmd_write = wr_n; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    n = 0;
    do begin @(negedge clk); n++; end while (!cmd_ready && n < 500);
    checks++;
    if (!cmd_ready) begin
      errors++;
      $display("FAIL cmd_accept: cmd_ready stayed %0b for %0d cycles, required 1", cmd_ready, n);
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    ref_wr(a, d, s);
    do_cmd(1'b1, a, d, s, 32'h0, 2'b00, 1'b0);
  endtask

  task automatic rd(input logic [15:0] a);
    logic [31:0] ed;
    ed = ref_mem.exists(int'(a[15:2])) ? ref_mem[int'(a[15:2])] : 32'h0;
    do_cmd(1'b0, a, 32'h0, 4'h0, ed, 2'b00, 1'b0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin @(negedge clk); n++; end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   b0, r0;
    logic [15:0] ra;
    areset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    for (int i = 0; i < 16384; i++) smem[i] = 32'h0;
    repeat (4) @(posedge clk);
    #1 areset = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_err_hung", 32'(err_hung), 0);
    chk("rst_awvalid", 32'(axi.awvalid), 0);
    chk("rst_wvalid", 32'(axi.wvalid), 0);
    chk("rst_arvalid", 32'(axi.arvalid), 0);
    chk("rst_bready", 32'(axi.bready), 0);
    chk("rst_rready", 32'(axi.rready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_resp", 32'(rsp_resp), 0);
    chk("rst_rsp_timeout", 32'(rsp_timeout), 0);
    chk("rst_awaddr", 32'(axi.awaddr), 0);

    // Latency with an always-ready, zero-wait slave.
    ref_wr(16'h0960, 32'h001F6000, 4'hF);
    e.data = 32'h0; e.resp = 2'b00; e.to = 1'b0;
    exp_q.push_back(e);
    @(posedge clk);
    #1 cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0960;
    cmd_wdata = 32'h001F6000; cmd_wstrb = 4'hF;
    @(negedge clk);
    chk("lat_cmd_ready", 32'(cmd_ready), 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    chk("lat_awvalid_n", 32'(axi.awvalid), 1);
    chk("lat_wvalid_n", 32'(axi.wvalid), 1);
    chk("lat_awaddr", 32'(axi.awaddr), 32'h0960);
    chk("lat_wstrb", 32'(axi.wstrb), 32'hF);
    chk("lat_wdata", axi.wdata, 32'h001F6000);
    chk("lat_cmd_ready_busy", 32'(cmd_ready), 0);
    @(posedge clk);
    #1;
    chk("lat_awvalid_n1", 32'(axi.awvalid), 0);
    chk("lat_wvalid_n1", 32'(axi.wvalid), 0);
    chk("lat_bready_n1", 32'(axi.bready), 1);
    @(posedge clk);
    #1;
    chk("lat_rsp_valid_n2", 32'(rsp_valid), 1);
    chk("lat_bready_n2", 32'(axi.bready), 0);
    drain();

    // W accepted well before AW.
    aw_block = 1'b1;
    b0 = b_hs;
    wr(16'h0010, 32'hA5A5_0F0F, 4'hF);
    r0 = 0;
    do begin @(negedge clk); r0++; end while (!(!axi.wvalid && axi.awvalid) && r0 < 50);
    chk("w_first_wvalid_low", 32'(axi.wvalid), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("w_first_awvalid_held", 32'(axi.awvalid), 1);
    end
    aw_block = 1'b0;
    drain();
    chk("w_first_one_b", 32'(b_hs - b0), 1);
    rd(16'h0010);

    // Bulk write then read-back under random back-pressure.
    rdy_pct = 60; max_dly = 3; rsp_pct = 70;
    for (int i = 0; i < 600; i++) wr(16'(4 * i), 32'(i), 4'hF);
    for (int i = 0; i < 600; i++) rd(16'(4 * i));
    rd(16'h0960);
    wr(16'h0000, 32'h0000_0000, 4'hF);
    wr(16'h0000, 32'h0000_AB00, 4'h2);
    rd(16'h0000);

    for (int i = 0; i < 300; i++) begin
      ra = 16'(4 * $urandom_range(1023));
      if ($urandom_range(1) == 1) wr(ra, $urandom, 4'($urandom_range(15)));
      else rd(ra);
    end
    drain();

    // Slave error on read.
    rd_err = 1'b1;
    do_cmd(1'b0, 16'h0040, 32'h0, 4'h0, 32'hDEADBEEF, 2'b10, 1'b0);
    drain();
    rd_err = 1'b0;
    chk("rerr_err_hung", 32'(err_hung), 0);
    chk("rerr_cmd_ready", 32'(cmd_ready), 1);

    // B never arrives: timeout and hung lock.
    rdy_pct = 100; rsp_pct = 100; max_dly = 0;
    bready_cnt = 0;
    no_b = 1'b1;
    do_cmd(1'b1, 16'h0080, 32'h1234_5678, 4'hF, 32'h0, 2'b10, 1'b1);
    drain();
    chk("to_err_hung", 32'(err_hung), 1);
    chk("to_cmd_ready", 32'(cmd_ready), 0);
    chk("to_bready_cycles", 32'(bready_cnt), TO);
    no_b = 1'b0;
    b0 = b_hs;
    repeat (20) @(negedge clk);
    chk("to_late_b_bready", 32'(bready_cnt), TO);
    chk("to_late_b_hs", 32'(b_hs - b0), 0);
    chk("to_still_hung", 32'(err_hung), 1);
    @(posedge clk);
    #1 areset = 1'b1;
    repeat (2) @(posedge clk);
    #1 areset = 1'b0;
    @(negedge clk);
    chk("to_rst_cmd_ready", 32'(cmd_ready), 1);
    chk("to_rst_err_hung", 32'(err_hung), 0);

    // Reset while AW is stalled.
    aw_block = 1'b1;
    r0 = rsp_cnt;
    @(posedge clk);
    #1 cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0100;
    cmd_wdata = 32'hCAFE_F00D; cmd_wstrb = 4'hF;
    @(negedge clk);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("abort_awvalid_pre", 32'(axi.awvalid), 1);
    @(posedge clk);
    #1 areset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_awvalid", 32'(axi.awvalid), 0);
    chk("abort_cmd_ready", 32'(cmd_ready), 1);
    chk("abort_rsp_valid", 32'(rsp_valid), 0);
    areset = 1'b0;
    aw_block = 1'b0;
    repeat (30) @(negedge clk);
    chk("abort_no_rsp", 32'(rsp_cnt - r0), 0);
    chk("abort_awvalid_after", 32'(axi.awvalid), 0);

    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_master_engine.md
Name: axi_lite_master_engine

Overview:
- Synthesizable AXI4-Lite master that turns single-beat commands from a simple valid/ready command port into full AXI4-Lite read or write transactions.
- Returns each result on a valid/ready response port.
- Drives the AXI slave port of the HDMI text controller, or any AXI4-Lite register IP, from on-chip logic: boot-time VRAM/palette init, self-test readback, hardware scripting.
- Generalises bus-master behaviour with parametrised widths, independent AW/W handshakes, per-byte strobes and a response timeout with a hang flag.

Parameters:
- C_AXI_DATA_WIDTH, 32: data bus width in bits; multiple of 8.
- C_AXI_ADDR_WIDTH, 16: byte-address width in bits.
- TIMEOUT_CYCLES, 1024: cycles to wait for B or R before aborting. 0 disables the timeout.

Ports:
- axi_aclk  in  1  clock; all logic is on the rising edge.
- axi_areset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  a command is presented.
- cmd_ready  out  1  engine accepts a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  C_AXI_ADDR_WIDTH  byte address.
- cmd_wdata  in  C_AXI_DATA_WIDTH  write data.
- cmd_wstrb  in  C_AXI_DATA_WIDTH/8  byte strobes (write only).
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result.
- rsp_data  out  C_AXI_DATA_WIDTH  read data; 0 for writes and timeouts.
- rsp_resp  out  2  AXI response code.
- rsp_timeout  out  1  result was produced by a timeout.
- err_hung  out  1  sticky; engine is locked after a timeout.
- axi_awaddr/awprot/awvalid out, axi_awready in: AXI AW channel.
- axi_wdata/wstrb/wvalid out, axi_wready in: AXI W channel.
- axi_bresp/bvalid in, axi_bready out: AXI B channel.
- axi_araddr/arprot/arvalid out, axi_arready in: AXI AR channel.
- axi_rdata/rresp/rvalid in, axi_rready out: AXI R channel.

Behaviour:
- Reset: on the edge with axi_areset=1, go to IDLE.
  - All AXI valid/ready outputs 0; rsp_valid 0; rsp_data 0; rsp_resp 0; rsp_timeout 0; err_hung 0; address/data/strb outputs 0.
  - Reset mid-transaction abandons it; no memory of outstanding slave responses.
- awprot and arprot are constant 3'b000. All outputs are registered.
- cmd_ready = (state==IDLE) && !err_hung. A command is accepted on the edge where cmd_valid && cmd_ready; addr, wdata and wstrb are latched.
- States: IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RESP.
- IDLE -> WR_AW_W (write):
  - Set axi_awvalid=1 and axi_wvalid=1 together after the accept edge.
  - AW and W handshakes are independent, in either order or the same cycle.
  - Each valid clears on the edge of its own handshake (valid && ready) and is never dropped before it.
- WR_AW_W -> WR_B on the edge where the second handshake completes; axi_bready=1 from that point.
- WR_B -> RESP on bvalid && bready:
  - rsp_resp=bresp, rsp_data=0, rsp_timeout=0, rsp_valid=1; axi_bready cleared.
- IDLE -> RD_AR (read): axi_arvalid=1, held until the arready edge. Then go to RD_R with axi_rready=1.
- RD_R -> RESP on rvalid && rready: rsp_data=rdata, rsp_resp=rresp, rsp_valid=1; axi_rready cleared.
- RESP: rsp_* held stable until the rsp_ready edge, then IDLE.
  - A new command can be accepted at the earliest one cycle after rsp_valid falls.
- Latency with an always-ready slave and zero-wait response:
  - Accept at edge N; AW, W and AR handshakes at N+1.
  - B or R handshake at the earliest N+2; rsp_valid is high after N+2.
- Timeout (TIMEOUT_CYCLES>0):
  - Counter clears on entry to WR_B or RD_R and increments each cycle in those states.
  - On the edge where count == TIMEOUT_CYCLES-1 without a handshake: go to RESP with rsp_resp=2'b10, rsp_data=0, rsp_timeout=1; drop bready/rready; set err_hung=1.
  - AW, W and AR waits are never timed out, because AXI forbids withdrawing a valid.
- Hung lock: after a timeout, err_hung stays 1 and cmd_ready stays 0 until reset. A late B or R is never acknowledged, so it cannot be misattributed to a later command.
- A handshake arriving on the same edge as timeout expiry wins: normal response, no timeout.
- Unexpected bvalid or rvalid outside WR_B/RD_R is ignored (ready stays 0).

Test Plan:
- Reset, always-ready slave. Write addr 0x0960, data 0x001F6000, strb 0xF -> AW and W handshake at edge N+1 with awaddr=0x0960 and wstrb=0xF; rsp_valid with rsp_resp=0, rsp_data=0.
- Slave asserts wready 3 cycles before awready -> wvalid falls after its own handshake; awvalid holds until awready; exactly one B accepted; rsp_resp=0.
- Write 600 words i to addr 4*i, then read back all 600 -> rsp_data==i for each; strb 0x2 write of 0x0000AB00 to addr 0 preceded by 0x00000000 -> readback 0x0000AB00.
- Slave returns rresp=2'b10 with rdata=0xDEADBEEF -> rsp_resp=2'b10, rsp_data=0xDEADBEEF, rsp_timeout=0, err_hung=0.
- TIMEOUT_CYCLES=8, slave never asserts bvalid -> rsp_timeout=1, rsp_resp=2'b10, err_hung=1, cmd_ready=0; a late bvalid is never acknowledged; after axi_areset pulse, cmd_ready=1 and err_hung=0.
- axi_areset asserted while awvalid=1 and awready=0 -> awvalid=0 and state IDLE on the next edge; rsp_valid never asserted for the aborted command.
